fpu_arbiter: RTL and testbench

- Shares one 32-bit FPU core (1 sign, 10 exp bias 511, 21 mant) among N_REQ requesters.
- Grants round-robin and captures the winner's operands.
- Sequences the core through a start/done handshake, then returns the result and status to the winner with an ID tag.
- Sits between requester masters and the single FPU instance. Only one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_arbiter_if.sv | 48 ++++
 rtl/fpu_arbiter_rr_picker.sv | 32 +++
 rtl/fpu_arbiter.sv | 127 ++++++++++++
 tb/tb_fpu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU arbiter types: 32-bit float format (1/10/21, bias 511), core status codes, arbiter states.
package fpu_pkg;

  localparam int EXP_W    = 10;
  localparam int MANT_W   = 21;
  localparam int EXP_BIAS = 511;
  localparam int FP_W     = 1 + EXP_W + MANT_W;

  typedef logic [FP_W-1:0] fp_t;

  typedef enum logic [3:0] {
    OVERFLOW  = 4'd0,
    UNDERFLOW = 4'd1,
    EXACT     = 4'd2,
    INEXACT   = 4'd3
  } status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef arb_state_t state_t;

  // Builds a float from sign, unbiased exponent and mantissa field.
  function automatic fp_t fp_pack(logic sign, int exp_unb, logic [MANT_W-1:0] mant);
    logic [EXP_W-1:0] e;
    e = EXP_W'(exp_unb + EXP_BIAS);
    return {sign, e, mant};
  endfunction

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester, core and response bundle of the FPU arbiter.
// slave is the arbiter's view; master is the surrounding requesters, core and response sink.
interface fpu_arbiter_if #(
  parameter int N_REQ = 4
);
  import fpu_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_op_a;
  logic [N_REQ*32-1:0] req_op_b;
  logic [N_REQ-1:0]    req_ready;

  fp_t     fpu_op_a;
  fp_t     fpu_op_b;
  logic    fpu_start;
  logic    fpu_done;
  fp_t     fpu_result;
  status_t fpu_status;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  fp_t             rsp_data;
  status_t         rsp_status;
  logic            rsp_timeout;
  logic            busy;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready,
    input  fpu_op_a, fpu_op_b, fpu_start,
    output fpu_done, fpu_result, fpu_status,
    input  rsp_valid, rsp_id, rsp_data, rsp_status, rsp_timeout, busy,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready,
    output fpu_op_a, fpu_op_b, fpu_start,
    input  fpu_done, fpu_result, fpu_status,
    output rsp_valid, rsp_id, rsp_data, rsp_status, rsp_timeout, busy,
    input  rsp_ready
  );

endinterface

// File: rtl/fpu_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester scanning from rr_ptr upward, wrapping.
// Zero latency; no flow control of its own.
module fpu_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  // Scan from the far end so the slot closest to rr_ptr is written last and wins.
  always_comb begin
    logic [ID_W-1:0] slot;
    slot      = '0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      slot = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[slot]) begin
        grant_any      = 1'b1;
        grant_idx      = slot;
        grant_oh       = '0;
        grant_oh[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin share of one FPU core, one op in flight; FPU_ARB_TIMEOUT_EN adds an abort after TIMEOUT WAIT cycles.
// Accept -> fpu_start next cycle -> rsp_valid one cycle after fpu_done; rsp_valid holds until rsp_ready, no grants meanwhile.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input logic          clock_100Khz,
  input logic          reset,
  fpu_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  rr_next;
  logic [N_REQ-1:0] grant_oh;
  logic             grant_any;
  fp_t              op_a_arr [N_REQ];
  fp_t              op_b_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign op_a_arr[i] = bus.req_op_a[32*i +: 32];
    assign op_b_arr[i] = bus.req_op_b[32*i +: 32];
  end

  fpu_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign rr_next       = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
  // Gated by reset so nothing is accepted while the core is held in reset.
  assign bus.req_ready = (reset && state == IDLE) ? grant_oh : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_id    = cur_id;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             to_hit;
  assign to_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign bus.rsp_timeout    = 1'b0;
`endif

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cur_id         <= '0;
      bus.fpu_op_a   <= '0;
      bus.fpu_op_b   <= '0;
      bus.fpu_start  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_status <= EXACT;
`ifdef FPU_ARB_TIMEOUT_EN
      bus.rsp_timeout <= 1'b0;
      wait_cnt        <= '0;
`endif
    end else begin
      bus.fpu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_id        <= grant_idx;
            bus.fpu_op_a  <= op_a_arr[grant_idx];
            bus.fpu_op_b  <= op_b_arr[grant_idx];
            bus.fpu_start <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // A done coinciding with the timeout cycle is a normal completion.
          if (bus.fpu_done) begin
            bus.rsp_data   <= bus.fpu_result;
            bus.rsp_status <= bus.fpu_status;
            bus.rsp_valid  <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
            bus.rsp_timeout <= 1'b0;
`endif
            state <= RESP;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (to_hit) begin
            bus.rsp_data    <= '0;
            bus.rsp_status  <= INEXACT;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= rr_next;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a latency-programmable FPU core stub.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clock_100Khz = 1'b0;
  logic reset        = 1'b0;
  always #5 clock_100Khz = ~clock_100Khz;

  fpu_arbiter_if #(.N_REQ(N)) bus ();

  fpu_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .bus          (bus)
  );

  typedef struct {
    int      id;
    fp_t     data;
    status_t st;
    logic    to;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  int   acc_cyc = 0, start_cyc = 0, rsp_cyc = 0;
  bit   prev_rsp = 0;
  bit   exp_to_mode = 0;
  exp_t sb[$];
  int   grant_log[$];
  fp_t  tb_op_a [N];
  fp_t  tb_op_b [N];

  int  stub_lat = 5;
  bit  stub_mute = 0;
  int  stub_cnt = 0;
  int  stray_req = 0, stray_seen = 0;
  fp_t cap_a, cap_b;

  for (genvar g = 0; g < N; g++) begin : g_ops
    assign bus.req_op_a[g*32 +: 32] = tb_op_a[g];
    assign bus.req_op_b[g*32 +: 32] = tb_op_b[g];
  end

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference behaviour of the core: equal operands double, otherwise xor.
  function automatic fp_t model_res(fp_t a, fp_t b);
    return (a == b) ? a + 32'h0020_0000 : a ^ b;
  endfunction

  function automatic status_t model_st(fp_t a, fp_t b);
    if (a == b) return EXACT;
    return a[31] ? UNDERFLOW : INEXACT;
  endfunction

  // Core stub: answers stub_lat cycles after start; stray pulses on request.
  always @(negedge clock_100Khz) begin
    if (!reset) begin
      stub_cnt     = 0;
      bus.fpu_done = 1'b0;
    end else if (stray_req != stray_seen) begin
      stray_seen     = stray_req;
      bus.fpu_done   = 1'b1;
      bus.fpu_result = 32'hDEAD_BEEF;
      bus.fpu_status = OVERFLOW;
    end else begin
      bus.fpu_done = 1'b0;
      if (bus.fpu_start && !stub_mute) begin
        cap_a    = bus.fpu_op_a;
        cap_b    = bus.fpu_op_b;
        stub_cnt = stub_lat;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          bus.fpu_done   = 1'b1;
          bus.fpu_result = model_res(cap_a, cap_b);
          bus.fpu_status = model_st(cap_a, cap_b);
        end
      end
    end
  end

  always @(posedge clock_100Khz) cyc++;

  // Monitor: push on accept, pop and compare on response handshake.
  always @(negedge clock_100Khz) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      prev_rsp = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.id   = i;
          e.data = exp_to_mode ? 32'h0 : model_res(tb_op_a[i], tb_op_b[i]);
          e.st   = exp_to_mode ? INEXACT : model_st(tb_op_a[i], tb_op_b[i]);
          e.to   = exp_to_mode;
          sb.push_back(e);
          grant_log.push_back(i);
          acc_cyc = cyc;
        end
      end
      if (bus.fpu_start) start_cyc = cyc;
      if (bus.rsp_valid && !prev_rsp) rsp_cyc = cyc;
      prev_rsp = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check_val("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("rsp_id", bus.rsp_id, e.id);
          check_val("rsp_data", bus.rsp_data, e.data);
          check_val("rsp_status", bus.rsp_status, e.st);
          check_val("rsp_timeout", bus.rsp_timeout, e.to);
        end
        n_rsp++;
      end
    end
  end

  task automatic wait_ready(int i);
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock_100Khz);
      if (bus.req_ready[i]) seen = 1;
    end
    check_val("accept_seen", seen, 1);
  endtask

  task automatic wait_rsp(int target);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clock_100Khz);
      if (n_rsp >= target) seen = 1;
    end
    check_val("rsp_seen", seen, 1);
  endtask

  task automatic run_one(int i, int lat, int exp_rsp_lat);
    int n0;
    n0 = n_rsp;
    stub_lat = lat;
    @(posedge clock_100Khz); #1;
    bus.req_valid[i] = 1'b1;
    wait_ready(i);
    @(posedge clock_100Khz); #1;
    bus.req_valid[i] = 1'b0;
    wait_rsp(n0 + 1);
    check_val("lat_start", start_cyc - acc_cyc, 1);
    check_val("lat_rsp", rsp_cyc - start_cyc, exp_rsp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, sz0;
    bit seen;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tb_op_a[i] = '0;
      tb_op_b[i] = '0;
    end

    // Reset values, with requests pending to confirm nothing is accepted.
    repeat (2) @(negedge clock_100Khz);
    bus.req_valid = 4'hF;
    @(negedge clock_100Khz);
    check_val("rst_req_ready", bus.req_ready, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_fpu_start", bus.fpu_start, 0);
    check_val("rst_rsp_status", bus.rsp_status, EXACT);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_rsp_id", bus.rsp_id, 0);
    check_val("rst_fpu_op_a", bus.fpu_op_a, 0);
    check_val("rst_rsp_timeout", bus.rsp_timeout, 0);
    bus.req_valid = '0;
    @(posedge clock_100Khz); #1;
    reset = 1'b1;

    // Single request: 1.0 op 1.0 -> 2.0, core answers in 5 cycles.
    tb_op_a[0] = 32'h3FE0_0000;
    tb_op_b[0] = 32'h3FE0_0000;
    run_one(0, 5, 6);
    check_val("single_rsp_at_7", rsp_cyc - acc_cyc, 7);

    // Stray done in IDLE must not disturb anything.
    stray_req++;
    repeat (3) @(negedge clock_100Khz);
    check_val("stray_idle_busy", bus.busy, 0);
    check_val("stray_idle_rsp_valid", bus.rsp_valid, 0);
    check_val("stray_idle_rsp_data", bus.rsp_data, 32'h4000_0000);

    // Contention from reset: all four held valid.
    @(posedge clock_100Khz); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      tb_op_a[i] = fp_pack(1'b0, i, '0);
      tb_op_b[i] = fp_pack(1'b0, i, 21'(i + 1));
    end
    bus.req_valid = 4'hF;
    stub_lat = 2;
    grant_log.delete();
    n0 = n_rsp;
    @(posedge clock_100Khz); #1;
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clock_100Khz);
      if (grant_log.size() >= 5) seen = 1;
    end
    check_val("contention_grants_seen", seen, 1);
    @(posedge clock_100Khz); #1;
    bus.req_valid = '0;
    wait_rsp(n0 + 5);
    for (int k = 0; k < 5; k++)
      check_val("contention_order", (k < grant_log.size()) ? grant_log[k] : -1, k % N);

    // Backpressure: response held 10 cycles, stray done mid-hold, req 3 waiting.
    tb_op_a[2] = fp_pack(1'b1, 3, 21'd5);
    tb_op_b[2] = fp_pack(1'b1, 3, 21'd5);
    tb_op_a[3] = fp_pack(1'b0, -2, 21'd7);
    tb_op_b[3] = fp_pack(1'b0, 4, 21'd9);
    n0 = n_rsp;
    @(posedge clock_100Khz); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1100;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock_100Khz);
      if (bus.rsp_valid) seen = 1;
    end
    check_val("bp_rsp_seen", seen, 1);
    bus.req_valid[2] = 1'b0;
    for (int h = 0; h < 10; h++) begin
      @(negedge clock_100Khz);
      if (h == 3) stray_req++;
      check_val("bp_rsp_valid", bus.rsp_valid, 1);
      check_val("bp_rsp_id", bus.rsp_id, 2);
      check_val("bp_rsp_data", bus.rsp_data, model_res(tb_op_a[2], tb_op_b[2]));
      check_val("bp_req_ready", bus.req_ready, 0);
    end
    @(posedge clock_100Khz); #1;
    bus.rsp_ready = 1'b1;
    sz0 = grant_log.size();
    wait_ready(3);
    @(posedge clock_100Khz); #1;
    bus.req_valid = '0;
    wait_rsp(n0 + 2);
    check_val("bp_next_grant", (sz0 < grant_log.size()) ? grant_log[sz0] : -1, 3);

    // Fastest core: response three cycles after accept.
    tb_op_a[1] = fp_pack(1'b0, 1, 21'd3);
    tb_op_b[1] = fp_pack(1'b0, 1, 21'd3);
    run_one(1, 1, 2);

    // Reset in WAIT: everything back to reset values, rr_ptr back to 0.
    stub_lat = 20;
    @(posedge clock_100Khz); #1;
    bus.req_valid[3] = 1'b1;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock_100Khz);
      if (bus.fpu_start) seen = 1;
    end
    check_val("rw_start_seen", seen, 1);
    @(posedge clock_100Khz);
    @(posedge clock_100Khz); #1;
    bus.req_valid = 4'b1010;
    reset = 1'b0;
    #1;
    check_val("rw_busy", bus.busy, 0);
    check_val("rw_rsp_valid", bus.rsp_valid, 0);
    check_val("rw_fpu_start", bus.fpu_start, 0);
    check_val("rw_fpu_op_a", bus.fpu_op_a, 0);
    check_val("rw_fpu_op_b", bus.fpu_op_b, 0);
    check_val("rw_req_ready", bus.req_ready, 0);
    check_val("rw_rsp_data", bus.rsp_data, 0);
    check_val("rw_rsp_status", bus.rsp_status, EXACT);
    check_val("rw_rsp_id", bus.rsp_id, 0);
    stub_lat = 3;
    n0 = n_rsp;
    sz0 = grant_log.size();
    @(posedge clock_100Khz); #1;
    reset = 1'b1;
    wait_ready(1);
    @(posedge clock_100Khz); #1;
    bus.req_valid = '0;
    wait_rsp(n0 + 1);
    check_val("rw_first_grant", (sz0 < grant_log.size()) ? grant_log[sz0] : -1, 1);

`ifdef FPU_ARB_TIMEOUT_EN
    // Silent core: abort response 9 cycles after start.
    stub_mute   = 1;
    exp_to_mode = 1;
    run_one(0, 0, TO + 1);
    stub_mute   = 0;
    exp_to_mode = 0;
    // Done in the last WAIT cycle wins over the timeout.
    run_one(0, TO, TO + 1);
`endif

    repeat (3) @(negedge clock_100Khz);
    check_val("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
